// File: rtl/slice_packer_pkg.sv
// Shared constants and types for the slice packer: slice geometry, FSM states, slice type.
package slice_packer_pkg;

  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int IDX_W   = 6;
  localparam int CNT_W   = 5;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic [SLICE_W-1:0] slice_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] p);
    return p == IDX_W'(DEPTH - 1);
  endfunction

endpackage

// File: rtl/slice_shift_reg.sv
// MSB-first serial-in shift register with a bit counter that flags the final bit of each slice.
module slice_shift_reg
  import slice_packer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   shift_en,
  input  logic   bit_in,
  output slice_t slice_next,
  output logic   last
);

  slice_t             shift;
  logic [CNT_W-1:0]   cnt;

  // slice_next is what the register would hold after this shift; on the last bit it is the full slice
  assign slice_next = {shift[SLICE_W-2:0], bit_in};
  assign last       = (cnt == CNT_W'(SLICE_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      shift <= slice_next;
      cnt   <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slice_packer.sv
// Serial-to-parallel slice packer: fills DEPTH slices from a bit stream, then drains them in order.
// Optional build macro SLICE_PARITY_EN adds slice_par and parity_acc outputs.
module slice_packer
  import slice_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init0,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output slice_t           slice_out,
  output logic [IDX_W-1:0] slice_idx,
  output logic             slice_valid,
  input  logic             slice_ready,
  output logic             busy,
  output logic             done
`ifdef SLICE_PARITY_EN
  ,
  output logic             slice_par,
  output slice_t           parity_acc
`endif
);

  state_t           state;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  slice_t           mem [DEPTH];

  slice_t           slice_next;
  logic             last_bit;
  logic             bit_xfer;
  logic             slice_xfer;
  logic             slice_wr;

  assign bit_ready   = (state == FILL);
  assign slice_valid = (state == DRAIN);
  assign busy        = (state == DRAIN);
  assign slice_idx   = rd_ptr;
  assign slice_out   = slice_valid ? mem[rd_ptr] : '0;

  assign bit_xfer    = bit_ready & bit_valid;
  assign slice_xfer  = slice_valid & slice_ready;
  // init0 outranks any handshake in the same cycle, so the bit or slice is dropped
  assign slice_wr    = bit_xfer & last_bit & ~init0;

  slice_shift_reg u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr        (init0),
    .shift_en   (bit_xfer & ~init0),
    .bit_in     (bit_in),
    .slice_next (slice_next),
    .last       (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (init0) begin
        state  <= FILL;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        case (state)
          FILL: begin
            if (slice_wr) begin
              wr_ptr <= wr_ptr + IDX_W'(1);
              if (is_last_idx(wr_ptr)) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (slice_xfer) begin
              rd_ptr <= rd_ptr + IDX_W'(1);
              if (is_last_idx(rd_ptr)) begin
                state <= FILL;
                done  <= 1'b1;
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  // Slice storage carries no reset; its contents are only observed after being written
  always_ff @(posedge clk) begin
    if (slice_wr) mem[wr_ptr] <= slice_next;
  end

`ifdef SLICE_PARITY_EN
  assign slice_par = ^slice_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_acc <= '0;
    end else if (init0) begin
      parity_acc <= '0;
    end else if (slice_xfer) begin
      parity_acc <= is_last_idx(rd_ptr) ? '0 : (parity_acc ^ slice_out);
    end
  end
`endif

endmodule

// File: tb/tb_slice_packer.sv
// Directed bench for slice_packer with a slice scoreboard; parity checks when SLICE_PARITY_EN is defined.
module tb_slice_packer;
  import slice_packer_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init0 = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             slice_ready = 1'b0;
  logic             bit_ready;
  logic             slice_valid;
  logic             busy;
  logic             done;
  slice_t           slice_out;
  logic [IDX_W-1:0] slice_idx;
`ifdef SLICE_PARITY_EN
  logic             slice_par;
  slice_t           parity_acc;
  slice_t           acc_model = '0;
`endif

  int     checks = 0;
  int     passes = 0;
  slice_t q[$];

  slice_packer dut (
    .clk         (clk),
    .rst         (rst),
    .init0       (init0),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .slice_out   (slice_out),
    .slice_idx   (slice_idx),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .busy        (busy),
    .done        (done)
`ifdef SLICE_PARITY_EN
    ,
    .slice_par   (slice_par),
    .parity_acc  (parity_acc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    @(negedge clk);
    while (!bit_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
    bit_in    = b;
    bit_valid = 1'b1;
  endtask

  task automatic send_slice(input slice_t s);
    for (int i = SLICE_W - 1; i >= 0; i--) send_bit(s[i]);
  endtask

  // Drain n slices; bp selects the 1,0,0,1 slice_ready pattern
  task automatic drain(input int n, input bit bp, input bit expect_done);
    int     acc = 0;
    int     cyc = 0;
    logic   rdy;
    slice_t d;
    while (acc < n && cyc < 1000) begin
      @(negedge clk);
      bit_valid = 1'b0;
      cyc++;
      rdy = bp ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      check("slice_valid", 32'(slice_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("bit_ready_drain", 32'(bit_ready), 32'd0);
      check("done_early", 32'(done), 32'd0);
      check("slice_idx", 32'(slice_idx), 32'(acc));
      check("slice_out", 32'(slice_out), 32'(q[0]));
`ifdef SLICE_PARITY_EN
      check("slice_par", 32'(slice_par), 32'(^q[0]));
      check("parity_acc", 32'(parity_acc), 32'(acc_model));
`endif
      slice_ready = rdy;
      if (rdy) begin
        d = q.pop_front();
        acc++;
`ifdef SLICE_PARITY_EN
        acc_model ^= d;
`endif
      end
    end
    if (acc < n) check("drain_timeout", 32'(acc), 32'(n));
    @(negedge clk);
    slice_ready = 1'b0;
    if (expect_done) begin
      check("done_pulse", 32'(done), 32'd1);
      check("valid_after_drain", 32'(slice_valid), 32'd0);
      check("ready_after_drain", 32'(bit_ready), 32'd1);
`ifdef SLICE_PARITY_EN
      acc_model = '0;
      check("parity_acc_clr", 32'(parity_acc), 32'(acc_model));
`endif
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
    end
  endtask

  initial begin
    slice_t     s;
    logic [5:0] k6;

    // Async reset with no clock edge involved
    #2 rst = 1'b1;
    #1;
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
    check("rst_slice_valid", 32'(slice_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_slice_out", 32'(slice_out), 32'd0);
    check("rst_slice_idx", 32'(slice_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 1: bit-order slice first, then {k,19'h5A5A5}; drain with backpressure
    for (int k = 0; k < DEPTH; k++) begin
      k6 = k[5:0];
      s  = (k == 0) ? 25'h1000000 : {k6, 19'h5A5A5};
      q.push_back(s);
      send_slice(s);
    end
    drain(DEPTH, 1'b1, 1'b1);

    // init0 mid-fill after 30 bits, colliding with a bit transfer
    for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    init0  = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    init0     = 1'b0;
    bit_valid = 1'b0;
    check("init0_fill_ready", 32'(bit_ready), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      s = slice_t'($urandom);
      q.push_back(s);
      send_slice(s);
    end
    drain(10, 1'b0, 1'b0);

    // init0 mid-drain at idx 10 while a slice is being accepted
    check("pre_init0_idx", 32'(slice_idx), 32'd10);
    check("pre_init0_out", 32'(slice_out), 32'(q[0]));
    init0       = 1'b1;
    slice_ready = 1'b1;
    @(negedge clk);
    init0       = 1'b0;
    slice_ready = 1'b0;
    check("init0_valid_drop", 32'(slice_valid), 32'd0);
    check("init0_no_done", 32'(done), 32'd0);
    check("init0_ready", 32'(bit_ready), 32'd1);
    check("init0_idx", 32'(slice_idx), 32'd0);
    @(negedge clk);
    check("init0_no_done_late", 32'(done), 32'd0);
    q.delete();
`ifdef SLICE_PARITY_EN
    acc_model = '0;
    check("init0_parity_clr", 32'(parity_acc), 32'(acc_model));
`endif

    // Fill 3: slices 3 and 1 lead, then reset mid-drain
    for (int k = 0; k < DEPTH; k++) begin
      s = (k == 0) ? 25'h0000003 : (k == 1) ? 25'h0000001 : slice_t'($urandom);
      q.push_back(s);
      send_slice(s);
    end
    drain(5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst2_bit_ready", 32'(bit_ready), 32'd1);
    check("rst2_slice_valid", 32'(slice_valid), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_slice_out", 32'(slice_out), 32'd0);
    check("rst2_slice_idx", 32'(slice_idx), 32'd0);
`ifdef SLICE_PARITY_EN
    check("rst2_parity_acc", 32'(parity_acc), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_no_done", 32'(done), 32'd0);
    check("rst2_fill", 32'(bit_ready), 32'd1);
    q.delete();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/slice_packer.md
Name: slice_packer

Overview:
- Serial-to-parallel receiver for the column-parity stage's 1-bit-per-cycle output stream.
- Packs each run of 25 bits into one 5x5 state slice and buffers a full state depth of 64 slices.
- Then drains the slices in order on a parallel valid/ready interface.
- Sits downstream of the column-parity datapath, as the consumer end of its bit stream.

Parameters:
SLICE_W, 25, bits per slice (5x5 lanes cross-section)
DEPTH, 64, slices per state (lane depth)
IDX_W, 6, width of slice index, equals clog2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
init0  input  1  synchronous clear of counters/FSM, returns to FILL
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  packer accepts a bit this cycle
slice_out  output  SLICE_W  drained slice data
slice_idx  output  IDX_W  index (depth position) of slice_out
slice_valid  output  1  slice_out/slice_idx valid
slice_ready  input  1  downstream accepts slice this cycle
busy  output  1  high in DRAIN
done  output  1  one-cycle pulse after last slice accepted

Behaviour:
- Reset (rst=1, async): FSM=FILL, bit counter=0, write pointer=0, read pointer=0, shift register=0. Outputs: bit_ready=1, slice_valid=0, slice_out=0, slice_idx=0, busy=0, done=0. Buffer contents are don't-care.
- Bit order: first bit of a slice lands in slice bit SLICE_W-1 (24), last bit in bit 0 (MSB-first, matching the producer's index 24-cnt).
- Bit handshake: a bit transfers on a clock edge where bit_valid & bit_ready.
- FILL state:
  - bit_ready=1.
  - Each transfer shifts bit_in into the shift register and increments the bit counter (0..24).
  - On the transfer with bit counter=24: the assembled slice ({shift[23:0],bit_in}) is written to buffer[write pointer] at that same edge, the bit counter wraps to 0, and the write pointer increments. No stall between slices.
  - When that write uses write pointer=DEPTH-1: the write pointer wraps to 0 and FSM goes to DRAIN at the same edge.
- DRAIN state:
  - bit_ready=0; busy=1; slice_valid=1.
  - slice_out=buffer[read pointer] (combinational read of the register array); slice_idx=read pointer.
  - On slice_valid & slice_ready, the read pointer increments.
  - Data and index hold stable while slice_ready=0.
  - When the accepted slice is DEPTH-1: the read pointer wraps to 0, FSM returns to FILL, and done=1 for exactly the next cycle.
- Latency: first slice is valid the cycle after the 1600th bit (64*25) is accepted.
- init0: synchronous; overrides all state except rst. Same state effect as reset (FSM=FILL, all counters=0, done=0, slice_valid=0). Buffer and shift register are not cleared. Mid-FILL, partial slices are discarded. Mid-DRAIN, remaining slices are dropped and no done pulse occurs.
- Simultaneous init0 and handshake: init0 wins; the transferring bit or slice is discarded.
- bit_valid in DRAIN is ignored (bit_ready=0); the producer must hold the bit.
- Reset mid-operation: immediate return to reset values, no done pulse.

Optional Feature:
SLICE_PARITY_EN
- Defined:
  - Adds output port slice_par (1 bit) = XOR of all SLICE_W bits of slice_out, valid with slice_valid and 0 otherwise.
  - Adds output parity_acc (SLICE_W bits): XOR of every slice accepted in the current drain. It clears on FILL entry, rst and init0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - constants SLICE_W=25, DEPTH=64, IDX_W=6;
  - the FSM state enum (FILL, DRAIN);
  - a slice_t typedef of SLICE_W bits.
- One sub-module: slice_shift_reg, a 25-bit MSB-first shift-in register with bit counter and last-bit flag.
- Buffer and pointers stay in the top.

Test Plan:
- Reset: assert rst mid-cycle -> bit_ready=1, slice_valid=0, busy=0, done=0, slice_out=0 immediately (async).
- Full fill/drain: stream 1600 bits, with slice k = 25-bit pattern {k[5:0],19'h5A5A5} sent MSB-first; slice_ready=1 -> 64 slices in index order 0..63, each slice_out matches its pattern; one done pulse; FSM back to FILL (bit_ready=1).
- Bit order: slice 0 bits = one 1 followed by 24 zeros -> slice_out=25'h1000000 at slice_idx=0.
- Backpressure: slice_ready toggling 1,0,0,1 during drain -> slice_out/slice_idx stable while low; no slices lost or duplicated; done only after idx 63 accepted.
- init0 mid-FILL after 30 bits: then send 1600 new bits -> slice 0 equals the first 25 new bits. init0 mid-DRAIN at idx 10 -> slice_valid drops next cycle, no done.
- SLICE_PARITY_EN build: slices 25'h0000003 and 25'h0000001 -> slice_par 0 then 1; parity_acc=25'h0000002 after both accepted.
